// File: rtl/gpio_ctrl.sv
// gpio_ctrl: WIDTH-bit GPIO port with set/clear/toggle writes, direction, synchronised inputs and rising-edge interrupts
// Ports: clk, rst_n (async active-low); we/re/addr/wr_data bus strobes and data;
// rd_data/rd_valid registered read response; gpio_in raw pads; gpio_out/gpio_oe
// output value and enables; irq registered level interrupt.
module gpio_ctrl #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] irq_en, irq_stat, in_prev, in_sync, rise, clr, out_next, rd_mux;
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise = in_sync & ~in_prev;
  // W1C mask; a same-cycle rise wins over the clear because it is ORed in afterwards
  assign clr = (we && addr == 3'd7) ? wr_data : '0;
  always_comb begin
    out_next = !we ? gpio_out :
               addr == 3'd0 ? wr_data :
               addr == 3'd1 ? gpio_out | wr_data :
               addr == 3'd2 ? gpio_out & ~wr_data :
               addr == 3'd3 ? gpio_out ^ wr_data : gpio_out;
    rd_mux = addr == 3'd0 ? gpio_out :
             addr == 3'd4 ? gpio_oe :
             addr == 3'd5 ? in_sync :
             addr == 3'd6 ? irq_en :
             addr == 3'd7 ? irq_stat : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q   <= '0;
      in_prev  <= '0;
      gpio_out <= OUT_RESET;
      gpio_oe  <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      in_prev  <= in_sync;
      gpio_out <= out_next;
      if (we && addr == 3'd4) gpio_oe <= wr_data;
      if (we && addr == 3'd6) irq_en <= wr_data;
      irq_stat <= (irq_stat & ~clr) | rise;
      irq      <= |(irq_stat & irq_en);
      rd_valid <= re;
      if (re) rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed bench for gpio_ctrl with a read-response scoreboard
module tb_gpio_ctrl;
  logic clk = 0, rst_n = 0, we = 0, re = 0, rd_valid, irq;
  logic [2:0] addr = '0;
  logic [7:0] wr_data = '0, gpio_in = '0, rd_data, gpio_out, gpio_oe;
  logic [7:0] q[$];
  int tests = 0, fails = 0;
  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rd_valid === 1'b1) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL rd_unexpected: observed rd_valid with data %h expected no response", rd_data);
      end
      if (q.size() != 0) chk("rd_data", rd_data, q.pop_front());
    end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1; addr = a; wr_data = d;
    @(negedge clk);
    we = 0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [7:0] exp);
    re = 1; addr = a; q.push_back(exp);
    @(negedge clk);
    re = 0;
    chk("rd_valid_pulse", rd_valid, 1);
  endtask
  initial begin
    idle(2);
    chk("rst_out", gpio_out, 8'hA5);
    chk("rst_oe", gpio_oe, 8'h00);
    chk("rst_irq", irq, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst_n = 1;
    wr(3'd0, 8'hF0); chk("out_write", gpio_out, 8'hF0);
    wr(3'd1, 8'h0F); chk("out_set", gpio_out, 8'hFF);
    wr(3'd2, 8'h81); chk("out_clr", gpio_out, 8'h7E);
    wr(3'd3, 8'hFF); chk("out_tgl", gpio_out, 8'h81);
    rd(3'd0, 8'h81);
    idle(1);
    chk("rd_hold", rd_data, 8'h81);
    chk("rd_valid_low", rd_valid, 0);
    rd(3'd1, 8'h00);
    rd(3'd3, 8'h00);
    wr(3'd4, 8'h3C); chk("dir_write", gpio_oe, 8'h3C);
    we = 1; re = 1; addr = 3'd4; wr_data = 8'h00; q.push_back(8'h3C);
    @(negedge clk);
    we = 0; re = 0;
    chk("dir_same_cycle", gpio_oe, 8'h00);
    chk("rd_valid_same_cycle", rd_valid, 1);
    wr(3'd5, 8'hFF);
    rd(3'd5, 8'h00);
    wr(3'd6, 8'h04);
    gpio_in = 8'h04;
    rd(3'd5, 8'h00);
    rd(3'd5, 8'h00);
    chk("irq_e2", irq, 0);
    rd(3'd5, 8'h04);
    chk("irq_e3", irq, 0);
    rd(3'd7, 8'h04);
    chk("irq_e4", irq, 1);
    wr(3'd7, 8'h04);
    chk("irq_clr_e1", irq, 1);
    idle(1);
    chk("irq_clr_e2", irq, 0);
    gpio_in = 8'h00;
    idle(3);
    gpio_in = 8'h04;
    idle(2);
    wr(3'd7, 8'h04);
    rd(3'd7, 8'h04);
    wr(3'd7, 8'h04);
    wr(3'd6, 8'h00);
    rd(3'd7, 8'h00);
    gpio_in = 8'h24;
    idle(3);
    rd(3'd7, 8'h20);
    idle(2);
    chk("irq_masked", irq, 0);
    wr(3'd6, 8'h20);
    chk("irq_en_e1", irq, 0);
    idle(1);
    chk("irq_en_e2", irq, 1);
    re = 1; addr = 3'd0;
    #2 rst_n = 0;
    @(negedge clk);
    re = 0;
    chk("rst_mid_rd_valid", rd_valid, 0);
    chk("rst_mid_rd_data", rd_data, 8'h00);
    chk("rst_mid_out", gpio_out, 8'hA5);
    chk("rst_mid_oe", gpio_oe, 8'h00);
    chk("rst_mid_irq", irq, 0);
    idle(1);
    chk("rst_mid_rd_valid2", rd_valid, 0);
    rst_n = 1;
    rd(3'd7, 8'h00);
    rd(3'd7, 8'h00);
    rd(3'd7, 8'h00);
    rd(3'd7, 8'h24);
    rd(3'd6, 8'h00);
    rd(3'd4, 8'h00);
    idle(2);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Parametrised successor to the 8-bit write-only output register: a WIDTH-bit general-purpose I/O port on the core's peripheral bus.
- Provides atomic set/clear/toggle writes, per-bit direction, synchronised input sampling, and rising-edge interrupt capture with an enable mask.
- Bus side is a simple single-cycle write strobe plus a registered read with one-cycle latency.

Parameters:
- WIDTH, 8, number of GPIO bits (1..32).
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (2..4).
- OUT_RESET, 0, reset value of the OUT register (WIDTH bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write strobe, one transfer per cycle
- re  in  1  read strobe
- addr  in  3  register index
- wr_data  in  WIDTH  write data
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- gpio_in  in  WIDTH  asynchronous pad inputs
- gpio_out  out  WIDTH  output register value
- gpio_oe  out  WIDTH  output enables, 1 = drive
- irq  out  1  level interrupt, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - OUT = OUT_RESET; DIR, IRQ_EN, IRQ_STAT = 0.
  - Synchroniser and in_prev = 0.
  - rd_data = 0, rd_valid = 0, irq = 0.
  - Reset mid-operation discards any in-flight read; no rd_valid follows.
- Register map by addr. All writes take effect at the clock edge where we=1.
  - 0 OUT: RW, plain write.
  - 1 SET: WO, OUT |= wr_data.
  - 2 CLR: WO, OUT &= ~wr_data.
  - 3 TGL: WO, OUT ^= wr_data.
  - 4 DIR: RW.
  - 5 IN: RO, synchronised input; writes ignored.
  - 6 IRQ_EN: RW.
  - 7 IRQ_STAT: RW1C, writing 1 clears a bit, writing 0 has no effect.
  - Reads of 1, 2 and 3 return 0.
- Outputs: gpio_out = OUT; gpio_oe = DIR. Both are direct register outputs, with no combinational path from wr_data.
- Read timing:
  - re=1 at edge N: rd_data is loaded with the selected register value sampled before any same-cycle write.
  - rd_valid=1 for the cycle following edge N, otherwise 0.
  - rd_data holds its value when re=0.
  - we and re in the same cycle are both performed; read returns the old value.
- Input path: gpio_in passes through the SYNC_STAGES flop chain to produce in_sync; in_prev is in_sync delayed by one cycle.
  - IN register reads in_sync.
  - Rising edge per bit: in_sync & ~in_prev. This is detected regardless of DIR and IRQ_EN.
- IRQ_STAT update each edge: STAT_next = (STAT & ~(we && addr==7 ? wr_data : 0)) | rise. Same-cycle edge and clear on a bit leaves it set.
- irq <= |(IRQ_STAT & IRQ_EN), registered one cycle after STAT/EN change. Clearing or masking deasserts irq one cycle later.
- Latency:
  - gpio_in 0→1 stable before edge E: in_sync high after edge E+SYNC_STAGES-1.
  - STAT bit set at edge E+SYNC_STAGES.
  - irq high after edge E+SYNC_STAGES+1.
- A pad high at reset release is captured as a rising edge, because in_prev resets to 0.
- Widths: wr_data and register bits above WIDTH do not exist. addr is fully decoded; no illegal addresses.

Test Plan:
- Reset, WIDTH=8, OUT_RESET=8'hA5 -> gpio_out=A5, gpio_oe=00, irq=0, rd_valid=0.
- Write OUT=F0, SET=0F, CLR=81, TGL=FF -> gpio_out after each write: F0, FF, 7E, 81. Read addr 0 -> rd_data=81 with rd_valid one cycle after re. Read addr 1 -> 00.
- Write DIR=3C -> gpio_oe=3C. Same-cycle we (addr 4, data 00) and re (addr 4) -> rd_data=3C, gpio_oe=00 after the edge.
- gpio_in 00→04 with IRQ_EN=04, SYNC_STAGES=2 -> IN reads 04 after 2 edges, STAT=04 at edge 3, irq=1 at edge 4. Write STAT=04 -> irq=0 two edges later.
- Rising edge on bit 2 in the same cycle as a W1C of bit 2 -> STAT bit 2 stays 1. Edge on bit 5 with IRQ_EN=00 -> STAT=20, irq=0. Setting IRQ_EN=20 -> irq=1 one edge later.
- Assert rst_n low mid-read (re issued, before the rd_valid cycle) -> no rd_valid; all registers at reset values; pad held high through reset -> STAT bit set SYNC_STAGES+1 edges after release.
